frame_config_sequencer: RTL

- Loads configuration frames into the tile configuration latches of one fabric region.
- Accepts a 32-bit word stream (header, then one data word per row) over a valid/ready handshake and assembles a full column frame.
- Drives the shared FrameData bus, then pulses exactly one FrameStrobe line with guaranteed setup and hold windows around the latch enable.
- Sits between the bitstream source (UART/SPI word assembler) and the per-tile ConfigMem latch arrays.

---
 rtl/frame_config_sequencer.sv | 199 +++++++++++++++++++
 1 files changed

// File: rtl/frame_config_sequencer.sv
// Configuration frame sequencer: assembles a column frame from a word stream
// (header + one word per row), drives it onto FrameData, then pulses exactly
// one FrameStrobe line with setup/hold windows around it.
//
// Ports:
//   CLK, RESET        clock, synchronous active-high reset
//   in_data/in_valid  stream word and its valid; in_ready accepts it
//   clear_err         clears the sticky err flag
//   FrameData         frame bus, row r at [32r+31:32r]
//   FrameStrobe       one-hot latch enables, index col*MaxFramesPerCol+frame
//   busy              state is not IDLE
//   err               sticky bad-sync / out-of-range flag
//   frames_done       count of completed strobes (wraps)
module frame_config_sequencer #(
    parameter int unsigned NumColumns      = 7,
    parameter int unsigned NumRows         = 23,
    parameter int unsigned MaxFramesPerCol = 20,
    parameter int unsigned FrameBitsPerRow = 32,
    parameter int unsigned SetupCycles     = 1,
    parameter int unsigned StrobeCycles    = 2,
    parameter int unsigned HoldCycles      = 1
) (
    input  logic                                  CLK,
    input  logic                                  RESET,
    input  logic [31:0]                           in_data,
    input  logic                                  in_valid,
    output logic                                  in_ready,
    input  logic                                  clear_err,
    output logic [NumRows*FrameBitsPerRow-1:0]    FrameData,
    output logic [NumColumns*MaxFramesPerCol-1:0] FrameStrobe,
    output logic                                  busy,
    output logic                                  err,
    output logic [15:0]                           frames_done
);

    localparam int unsigned DataW      = NumRows * FrameBitsPerRow;
    localparam int unsigned NumStrobes = NumColumns * MaxFramesPerCol;
    localparam int unsigned IdxW       = (NumStrobes > 1) ? $clog2(NumStrobes) : 1;
    localparam int unsigned MaxA       = (NumRows > SetupCycles) ? NumRows : SetupCycles;
    localparam int unsigned MaxB       = (StrobeCycles > HoldCycles) ? StrobeCycles : HoldCycles;
    localparam int unsigned CntMax     = (MaxA > MaxB) ? MaxA : MaxB;
    localparam int unsigned CntW       = $clog2(CntMax + 1);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_LOAD   = 3'd1;
    localparam logic [2:0] ST_SKIP   = 3'd2;
    localparam logic [2:0] ST_SETUP  = 3'd3;
    localparam logic [2:0] ST_STROBE = 3'd4;
    localparam logic [2:0] ST_HOLD   = 3'd5;

    logic [2:0]            state_q, state_d;
    logic [CntW-1:0]       cnt_q, cnt_d;
    logic [IdxW-1:0]       idx_q, idx_d;
    logic [DataW-1:0]      frame_data_q, frame_data_d;
    logic [NumStrobes-1:0] strobe_q, strobe_d;
    logic                  in_ready_q, in_ready_d;
    logic                  busy_q, busy_d;
    logic                  err_q, err_d;
    logic [15:0]           frames_done_q, frames_done_d;

    logic       accept;
    logic       err_set;
    logic [7:0] hdr_col;
    logic [7:0] hdr_frame;

    assign accept    = in_valid && in_ready_q;
    assign hdr_col   = in_data[23:16];
    assign hdr_frame = in_data[15:8];

    // Next-state, datapath and registered-output computation
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        idx_d         = idx_q;
        frame_data_d  = frame_data_q;
        frames_done_d = frames_done_q;
        err_set       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (in_data[31:24] != 8'hA5) begin
                        err_set = 1'b1;
                    end else if (32'(hdr_col) >= NumColumns ||
                                 32'(hdr_frame) >= MaxFramesPerCol) begin
                        // Payload rows must still be drained to stay word-aligned
                        err_set = 1'b1;
                        cnt_d   = '0;
                        state_d = ST_SKIP;
                    end else begin
                        idx_d   = IdxW'(32'(hdr_col) * MaxFramesPerCol + 32'(hdr_frame));
                        cnt_d   = '0;
                        state_d = ST_LOAD;
                    end
                end
            end
            ST_LOAD: begin
                if (accept) begin
                    for (int unsigned r = 0; r < NumRows; r++) begin
                        if (cnt_q == CntW'(r)) begin
                            frame_data_d[r*FrameBitsPerRow +: FrameBitsPerRow] =
                                FrameBitsPerRow'(in_data);
                        end
                    end
                    if (cnt_q == CntW'(NumRows - 1)) begin
                        cnt_d   = '0;
                        state_d = ST_SETUP;
                    end else begin
                        cnt_d = cnt_q + CntW'(1);
                    end
                end
            end
            ST_SKIP: begin
                if (accept) begin
                    if (cnt_q == CntW'(NumRows - 1)) begin
                        cnt_d   = '0;
                        state_d = ST_IDLE;
                    end else begin
                        cnt_d = cnt_q + CntW'(1);
                    end
                end
            end
            ST_SETUP: begin
                if (cnt_q == CntW'(SetupCycles - 1)) begin
                    cnt_d   = '0;
                    state_d = ST_STROBE;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            ST_STROBE: begin
                if (cnt_q == CntW'(StrobeCycles - 1)) begin
                    cnt_d         = '0;
                    frames_done_d = frames_done_q + 16'd1;
                    state_d       = ST_HOLD;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            ST_HOLD: begin
                if (cnt_q == CntW'(HoldCycles - 1)) begin
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = ST_IDLE;
            end
        endcase

        // A new error in the same cycle as clear_err wins
        err_d = err_q;
        if (clear_err) err_d = 1'b0;
        if (err_set)   err_d = 1'b1;

        // Outputs follow the next state so they line up with state_q
        in_ready_d = (state_d == ST_IDLE) || (state_d == ST_LOAD) || (state_d == ST_SKIP);
        busy_d     = (state_d != ST_IDLE);
        for (int unsigned i = 0; i < NumStrobes; i++) begin
            strobe_d[i] = (state_d == ST_STROBE) && (idx_q == IdxW'(i));
        end
    end

    // State and output registers
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q       <= ST_IDLE;
            cnt_q         <= '0;
            idx_q         <= '0;
            frame_data_q  <= '0;
            strobe_q      <= '0;
            in_ready_q    <= 1'b0;
            busy_q        <= 1'b0;
            err_q         <= 1'b0;
            frames_done_q <= '0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            idx_q         <= idx_d;
            frame_data_q  <= frame_data_d;
            strobe_q      <= strobe_d;
            in_ready_q    <= in_ready_d;
            busy_q        <= busy_d;
            err_q         <= err_d;
            frames_done_q <= frames_done_d;
        end
    end

    assign in_ready    = in_ready_q;
    assign FrameData   = frame_data_q;
    assign FrameStrobe = strobe_q;
    assign busy        = busy_q;
    assign err         = err_q;
    assign frames_done = frames_done_q;

endmodule
